// File: rtl/midi_trigger_scheduler_pkg.sv
// MIDI trigger scheduler shared definitions.
// Note-On opcode, FSM encodings, data-byte width, grant bundle.
package midi_trigger_scheduler_pkg;

  localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
  localparam int MIDI_DATA_W = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STATUS = 2'd1,
    S_NOTE   = 2'd2,
    S_VEL    = 2'd3
  } state_t;

  typedef struct packed {
    logic [MIDI_DATA_W-1:0] note;
    logic [MIDI_DATA_W-1:0] vel;
  } msg_t;

  // Velocity 0 would read as Note-Off, so clamp to 1.
  function automatic logic [MIDI_DATA_W-1:0] note_vel(
    input logic [MIDI_DATA_W-1:0] v
  );
    return (v == '0) ? 7'd1 : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request after last.
// Shared with the XBee/LCD TX sharing logic.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/midi_trigger_scheduler.sv
// Shares one MIDI TX byte stream between N_SRC drum triggers.
// Optional running status: define MIDI_RUNNING_STATUS_EN.
module midi_trigger_scheduler
  import midi_trigger_scheduler_pkg::*;
#(
  parameter int N_SRC      = 5,
  parameter int NOTE_BASE  = 36,
  parameter int CHANNEL    = 9,
  parameter int RS_REFRESH = 16384
) (
  input  logic               SYSCLK,
  input  logic               NSYSRESET,
  input  logic [N_SRC-1:0]   trig,
  input  logic [7*N_SRC-1:0] vel,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [N_SRC-1:0]   ovf,
  input  logic               ovf_clr
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t               state, state_d;
  logic [N_SRC-1:0]     trig_q, rise;
  logic [N_SRC-1:0]     pending, grant_oh;
  logic [6:0]           vel_r [N_SRC];
  logic [IW-1:0]        last_grant, gnt_idx;
  logic                 gnt_valid, gnt_fire;
  logic                 accept, rs_skip;
  msg_t                 msg;

  assign rise     = trig & ~trig_q;
  assign gnt_fire = (state == S_IDLE) & gnt_valid;
  assign grant_oh = gnt_fire ? (N_SRC'(1) << gnt_idx)
                             : '0;
  assign accept   = tx_valid & tx_ready;
  assign busy     = (state != S_IDLE) | (|pending);

  rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
    .req       (pending),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Previous trigger level for rising-edge detection.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) trig_q <= '0;
    else            trig_q <= trig;
  end

  // Pending flags, sticky overflow and captured velocities.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      pending <= '0;
      ovf     <= '0;
      for (int i = 0; i < N_SRC; i++) vel_r[i] <= '0;
    end else begin
      pending <= (pending & ~grant_oh) | rise;
      ovf     <= (ovf & {N_SRC{~ovf_clr}})
               | (rise & pending & ~grant_oh);
      for (int i = 0; i < N_SRC; i++) begin
        if (rise[i]) vel_r[i] <= note_vel(vel[7*i +: 7]);
      end
    end
  end

  // Latch the granted note/velocity and rotate priority.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      last_grant <= IW'(N_SRC - 1);
      msg        <= '0;
    end else if (gnt_fire) begin
      last_grant <= gnt_idx;
      msg.note   <= 7'(NOTE_BASE)
                  + {{(7-IW){1'b0}}, gnt_idx};
      msg.vel    <= vel_r[gnt_idx];
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  localparam int CW = $clog2(RS_REFRESH + 1);

  logic [CW-1:0] idle_cnt;
  logic          rs_seen;

  // Idle-time counter and "status already sent" flag.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      idle_cnt <= '0;
      rs_seen  <= 1'b0;
    end else begin
      if (accept)
        idle_cnt <= '0;
      else if (state == S_IDLE &&
               idle_cnt != CW'(RS_REFRESH))
        idle_cnt <= idle_cnt + CW'(1);
      if (state == S_STATUS && tx_ready)
        rs_seen <= 1'b1;
    end
  end

  assign rs_skip = rs_seen &
                   (idle_cnt < CW'(RS_REFRESH));
`else
  wire unused_rs = (RS_REFRESH != 0);

  assign rs_skip = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) state <= S_IDLE;
    else            state <= state_d;
  end

  // Next state and byte-stream outputs.
  always_comb begin
    state_d  = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (gnt_valid)
          state_d = rs_skip ? S_NOTE : S_STATUS;
      end
      S_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = {MIDI_NOTE_ON, 4'(CHANNEL)};
        if (tx_ready) state_d = S_NOTE;
      end
      S_NOTE: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, msg.note};
        if (tx_ready) state_d = S_VEL;
      end
      S_VEL: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, msg.vel};
        if (tx_ready) state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_midi_trigger_scheduler.sv
// Bench for midi_trigger_scheduler: queue-based byte model.
// Expects RS_REFRESH override; honours MIDI_RUNNING_STATUS_EN.
module tb_midi_trigger_scheduler;

  localparam int N  = 5;
  localparam int NB = 36;
  localparam int CH = 9;
  localparam int RS = 40;

  logic           SYSCLK = 1'b0;
  logic           NSYSRESET = 1'b0;
  logic [N-1:0]   trig = '0;
  logic [7*N-1:0] vel = '0;
  logic           tx_ready = 1'b0;
  logic           ovf_clr = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           busy;
  logic [N-1:0]   ovf;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]  m_pend, m_ovf, m_tq;
  logic [6:0]    m_vel [N];
  int            m_last, m_cnt;
  bit            m_seen;
  byte unsigned  m_q [$];
  byte unsigned  acc [$];

  midi_trigger_scheduler #(
    .N_SRC(N), .NOTE_BASE(NB),
    .CHANNEL(CH), .RS_REFRESH(RS)
  ) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .trig(trig), .vel(vel),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7*N-1:0] vs(int s, int v);
    logic [7*N-1:0] r;
    r = '0;
    r[7*s +: 7] = 7'(v);
    return r;
  endfunction

  function automatic void m_reset();
    m_pend = '0;
    m_ovf  = '0;
    m_tq   = '0;
    for (int i = 0; i < N; i++) m_vel[i] = '0;
    m_last = N - 1;
    m_cnt  = 0;
    m_seen = 0;
    m_q.delete();
  endfunction

  function automatic void model_edge(
    logic [N-1:0] t, logic [7*N-1:0] v, bit rdy, bit clr);
    logic [N-1:0] rise, oldp;
    int g;
    bit skip;
    rise = t & ~m_tq;
    oldp = m_pend;
    g = -1;
    if (m_q.size() != 0) begin
      if (rdy) begin
        if (m_q[0] >= 8'h80) m_seen = 1;
        void'(m_q.pop_front());
        m_cnt = 0;
      end
    end else begin
`ifdef MIDI_RUNNING_STATUS_EN
      skip = m_seen && (m_cnt < RS);
`else
      skip = 0;
`endif
      if (m_pend != 0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (g < 0 && m_pend[j]) g = j;
        end
        m_pend[g] = 1'b0;
        m_last = g;
        if (!skip) m_q.push_back(8'h90 | CH);
        m_q.push_back(8'(NB + g));
        m_q.push_back({1'b0, m_vel[g]});
      end
      if (m_cnt < RS) m_cnt++;
    end
    if (clr) m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin
        if (oldp[i] && i != g) m_ovf[i] = 1'b1;
        m_vel[i] = (v[7*i +: 7] == 0) ? 7'd1 : v[7*i +: 7];
        m_pend[i] = 1'b1;
      end
    end
    m_tq = t;
  endfunction

  task automatic check_outs();
    chk("tx_valid", tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
    chk("busy", busy, (m_q.size() != 0) || (|m_pend));
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic step(logic [N-1:0] t, logic [7*N-1:0] v,
                      bit rdy, bit clr);
    check_outs();
    if (tx_valid && rdy) acc.push_back(tx_data);
    trig = t;
    vel = v;
    tx_ready = rdy;
    ovf_clr = clr;
    model_edge(t, v, rdy, clr);
    @(posedge SYSCLK);
    @(negedge SYSCLK);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_pend != 0) && n < 40) begin
      step(trig, vel, 1'b1, 1'b0);
      n++;
    end
    if (n >= 40) chk("drain_timeout", 1, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step('0, vel, 1'b1, 1'b0);
  endtask

  logic [N-1:0]   rt;
  logic [7*N-1:0] rv;
  int             n;

  initial begin
    m_reset();
    @(negedge SYSCLK);
    @(negedge SYSCLK);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, '0);
    NSYSRESET = 1'b1;
    idle(2);

    // simultaneous triggers, then wrap-around order
    acc.delete();
    rv = vs(0, 50) | vs(1, 50) | vs(4, 50);
    step(5'b10011, rv, 1'b1, 1'b0);
    drain();
    chk("t3_len", acc.size(), 9);
    chk("t3_n0", acc[1], 36);
    chk("t3_n1", acc[4], 37);
    chk("t3_n2", acc[7], 40);
    step('0, rv, 1'b1, 1'b0);
    acc.delete();
    step(5'b10001, rv, 1'b1, 1'b0);
    drain();
    chk("t3w_len", acc.size(), 6);
    chk("t3w_n0", acc[1], 36);
    chk("t3w_n1", acc[4], 40);
    step('0, rv, 1'b1, 1'b0);

    // single event, source 2, vel 100
    acc.delete();
    step(5'b00100, vs(2, 100), 1'b1, 1'b0);
    step(5'b00100, vs(2, 100), 1'b1, 1'b0);
    chk("t2_lat", tx_valid, 1'b1);
    drain();
    chk("t2_len", acc.size(), 3);
    chk("t2_b0", acc[0], 8'h99);
    chk("t2_b1", acc[1], 8'h26);
    chk("t2_b2", acc[2], 8'h64);
    step('0, vel, 1'b1, 1'b0);

    // backpressure during NOTE byte
    acc.delete();
    step(5'b00001, vs(0, 77), 1'b1, 1'b0);
    n = 0;
    while (!(m_q.size() == 2 && m_q[0] == 8'h24) && n < 10) begin
      step(trig, vel, 1'b1, 1'b0);
      n++;
    end
    if (n >= 10) chk("bp_timeout", 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(trig, vel, 1'b0, 1'b0);
      chk("bp_note", tx_data, 8'h24);
      chk("bp_valid", tx_valid, 1'b1);
    end
    drain();
    chk("t4_len", acc.size(), 3);
    chk("t4_b0", acc[0], 8'h99);
    chk("t4_b1", acc[1], 8'h24);
    chk("t4_b2", acc[2], 8'h4d);
    step('0, vel, 1'b1, 1'b0);

    // overflow with zero velocity on source 3
    acc.delete();
    step(5'b00001, vs(0, 10), 1'b0, 1'b0);
    step(5'b01001, vs(0, 10) | vs(3, 20), 1'b0, 1'b0);
    step(5'b00001, vs(0, 10), 1'b0, 1'b0);
    step(5'b01001, vs(0, 10), 1'b0, 1'b0);
    chk("t5_ovf", ovf, 5'b01000);
    drain();
    chk("t5_len", acc.size(), 6);
    chk("t5_v0", acc[2], 8'h0a);
    chk("t5_b3", acc[3], 8'h99);
    chk("t5_n3", acc[4], 8'h27);
    chk("t5_v3", acc[5], 8'h01);
    step('0, vel, 1'b1, 1'b1);
    step('0, vel, 1'b1, 1'b0);
    chk("t5_clr", ovf, '0);

    // randomized traffic
    rt = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) rt[b] = ~rt[b];
      rv = {$urandom(), $urandom()};
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) rv[7*b +: 7] = '0;
      step(rt, rv, $urandom_range(3) != 0,
           $urandom_range(15) == 0);
    end
    step('0, rv, 1'b1, 1'b0);
    drain();

    // running status: two close events, one after refresh
    idle(RS + 2);
    acc.delete();
    step(5'b00001, vs(0, 30), 1'b1, 1'b0);
    idle(4);
    step(5'b00010, vs(1, 40), 1'b1, 1'b0);
    step('0, vel, 1'b1, 1'b0);
    drain();
    idle(RS + 2);
    step(5'b00100, vs(2, 50), 1'b1, 1'b0);
    step('0, vel, 1'b1, 1'b0);
    drain();
`ifdef MIDI_RUNNING_STATUS_EN
    chk("t6_len", acc.size(), 8);
    chk("t6_b3", acc[3], 8'h25);
    chk("t6_b5", acc[5], 8'h99);
`else
    chk("t6_len", acc.size(), 9);
    chk("t6_b3", acc[3], 8'h99);
    chk("t6_b6", acc[6], 8'h99);
`endif
    chk("t6_b0", acc[0], 8'h99);

    // reset in the middle of a message
    step(5'b00010, vs(1, 60), 1'b1, 1'b0);
    n = 0;
    while (!(m_q.size() == 2) && n < 10) begin
      step(trig, vel, 1'b1, 1'b0);
      n++;
    end
    if (n >= 10) chk("t1_timeout", 1, 0);
    chk("t1_pre_valid", tx_valid, 1'b1);
    step(5'b01010, vs(3, 5), 1'b0, 1'b0);
    trig = '0;
    NSYSRESET = 1'b0;
    #1;
    chk("t1_tx_data", tx_data, 8'h00);
    chk("t1_tx_valid", tx_valid, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_ovf", ovf, '0);
    m_reset();
    @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    idle(3);
    chk("t1_post_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
